// File: rtl/debounce_sched_if.sv
// debounce_sched_if: valid/ready change-event channel carrying {channel, level}.
// The debouncer drives it through the master modport; the consumer uses slave.
interface debounce_sched_if #(
    parameter int N_CH = 4
);
    localparam int CHW = $clog2(N_CH);

    logic           evt_valid;
    logic           evt_ready;
    logic [CHW-1:0] evt_ch;
    logic           evt_level;

    modport master (output evt_valid, output evt_ch, output evt_level, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_level, output evt_ready);
endinterface

// File: rtl/debounce_sched.sv
// debounce_sched: time-multiplexed debouncer for N_CH raw inputs.
// Each input is double-flop synchronized; a prescaler tick services one
// channel (round-robin) through a single shared compare/increment datapath.
// A channel flips after DB_MAX consecutive mismatching serves and posts a
// {channel, new level} event on a valid/ready channel; when the event buffer
// is full and nothing drains that cycle the event is dropped and ovf sticks.
// Build option: define DEBOUNCE_SCHED_EVT_FIFO_EN for a 4-entry in-order
// event FIFO; without it the buffer is a single holding register.
module debounce_sched #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 8,
    parameter int DB_MAX   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  in_i,
    output logic [N_CH-1:0]  out_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    debounce_sched_if.master evt
);
    localparam int CHW = $clog2(N_CH);
    localparam int PW  = $clog2(TICK_DIV);

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           lvl;
    } evt_t;

    logic [N_CH-1:0]      sync1_q, sync2_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic [CHW-1:0]       ptr_q, ptr_d;
    logic [N_CH-1:0][3:0] cnt_q, cnt_d;
    logic [N_CH-1:0]      out_q, out_d;
    logic [3:0]           cur_cnt;
    logic                 tick, mismatch, flip;
    logic                 accept, full, push, drop;
    logic                 ovf_q;
    evt_t                 new_evt;

    // Two-flop synchronizer; only sync2_q is ever looked at by the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    // N_CH is a power of two, so the pointer wraps naturally.
    assign ptr_d   = tick ? ptr_q + 1'b1 : ptr_q;

    // Prescaler and round-robin service pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ptr_q   <= '0;
        end else begin
            presc_q <= presc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cur_cnt  = cnt_q[ptr_q];
    assign mismatch = sync2_q[ptr_q] ^ out_q[ptr_q];
    assign flip     = tick && mismatch && (cur_cnt == 4'(DB_MAX - 1));
    assign new_evt  = '{ch: ptr_q, lvl: ~out_q[ptr_q]};

    // Shared service datapath: only the pointed-to channel may change.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (tick) begin
            if (!mismatch) begin
                cnt_d[ptr_q] = '0;
            end else if (flip) begin
                cnt_d[ptr_q] = '0;
                out_d[ptr_q] = ~out_q[ptr_q];
            end else begin
                cnt_d[ptr_q] = cur_cnt + 4'd1;
            end
        end
    end

    // Per-channel counters and debounced levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_o  = out_q;
    assign accept = evt.evt_valid && evt.evt_ready;
    // A same-cycle drain frees the slot the new event needs.
    assign push   = flip && (!full || accept);
    assign drop   = flip && full && !accept;

`ifdef DEBOUNCE_SCHED_EVT_FIFO_EN
    evt_t [3:0] mem_q;
    logic [1:0] wr_q, rd_q;
    logic [2:0] fcnt_q;

    assign full = (fcnt_q == 3'd4);

    // In-order 4-entry event FIFO; a push into a full FIFO only happens
    // together with a pop, so it overwrites the slot being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= new_evt;
                wr_q        <= wr_q + 1'b1;
            end
            if (accept) begin
                rd_q <= rd_q + 1'b1;
            end
            fcnt_q <= fcnt_q + {2'b00, push} - {2'b00, accept};
        end
    end

    assign evt.evt_valid = (fcnt_q != 3'd0);
    assign evt.evt_ch    = mem_q[rd_q].ch;
    assign evt.evt_level = mem_q[rd_q].lvl;
`else
    logic vld_q;
    evt_t hold_q;

    assign full = vld_q;

    // Single-entry holding register; load has priority over drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            hold_q <= '0;
        end else if (push) begin
            vld_q  <= 1'b1;
            hold_q <= new_evt;
        end else if (accept) begin
            vld_q  <= 1'b0;
        end
    end

    assign evt.evt_valid = vld_q;
    assign evt.evt_ch    = hold_q.ch;
    assign evt.evt_level = hold_q.lvl;
`endif

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_debounce_sched.sv
// tb_debounce_sched: scoreboard bench. A serve-level reference model predicts
// debounced levels, event order and overflow; a negedge monitor compares.
module tb_debounce_sched;
    localparam int N_CH     = 4;
    localparam int TICK_DIV = 8;
    localparam int DB_MAX   = 12;
`ifdef DEBOUNCE_SCHED_EVT_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] in_i = '0;
    logic [N_CH-1:0] out_o;
    logic            ovf_o;
    logic            ovf_clr_i = 1'b0;

    debounce_sched_if #(.N_CH(N_CH)) evt_if ();

    debounce_sched #(.N_CH(N_CH), .TICK_DIV(TICK_DIV), .DB_MAX(DB_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_i      (in_i),
        .out_o     (out_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .evt       (evt_if.master)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int ch; bit lvl; } ev_t;

    // reference model state
    int              cyc = 0;
    logic [N_CH-1:0] h_a = '0, h_b = '0, m_lvl = '0;
    int              run [N_CH];
    bit              m_ovf = 0;
    bit              flip_next = 0;
    ev_t             exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model: count cycles since reset release; every TICK_DIV-th cycle one
    // channel (round-robin) gets a sample of its input from two edges back.
    initial begin : model
        int c, nc;
        bit dropped;
        foreach (run[i]) run[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc = 0; h_a = '0; h_b = '0; m_lvl = '0; m_ovf = 0; flip_next = 0;
                exp_q.delete();
                foreach (run[i]) run[i] = 0;
            end else begin
                cyc++;
                dropped = 0;
                if (cyc % TICK_DIV == 0) begin
                    c = (cyc / TICK_DIV - 1) % N_CH;
                    if (h_b[c] != m_lvl[c]) begin
                        run[c]++;
                        if (run[c] == DB_MAX) begin
                            run[c]   = 0;
                            m_lvl[c] = ~m_lvl[c];
                            if (exp_q.size() < CAP) exp_q.push_back('{c, m_lvl[c]});
                            else begin m_ovf = 1; dropped = 1; end
                        end
                    end else begin
                        run[c] = 0;
                    end
                end
                if (!dropped && ovf_clr_i) m_ovf = 0;
                h_b = h_a;
                h_a = in_i;
                nc = cyc + 1;
                flip_next = 0;
                if (nc % TICK_DIV == 0) begin
                    c = (nc / TICK_DIV - 1) % N_CH;
                    flip_next = (h_b[c] != m_lvl[c]) && (run[c] == DB_MAX - 1);
                end
            end
        end
    end

    // Monitor: compare levels/flags every cycle; pop the scoreboard on transfer.
    initial begin : monitor
        forever begin
            @(negedge clk);
            chk("out", int'(out_o), int'(m_lvl));
            chk("evt_valid", int'(evt_if.evt_valid), int'(exp_q.size() != 0));
            chk("ovf", int'(ovf_o), int'(m_ovf));
            if (evt_if.evt_valid && exp_q.size() != 0) begin
                chk("evt_ch", int'(evt_if.evt_ch), exp_q[0].ch);
                chk("evt_level", int'(evt_if.evt_level), int'(exp_q[0].lvl));
                if (evt_if.evt_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        bit found;
        evt_if.evt_ready = 1'b0;
        #1;
        chk("rst_out", int'(out_o), 0);
        chk("rst_valid", int'(evt_if.evt_valid), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        chk("rst_evt_ch", int'(evt_if.evt_ch), 0);
        step(3);
        rst = 1'b0;

        // steady rise on channel 2, consumer always ready
        evt_if.evt_ready = 1'b1;
        in_i[2] = 1'b1;
        step(350);
        chk("A_early", int'(out_o), 0);
        step(50);
        chk("A_rise", int'(out_o), 4'b0100);

        // channel 1 with a bounce about eight serves in
        in_i[1] = 1'b1;
        step(7 * 32 + 16);
        in_i[1] = 1'b0;
        step(32);
        in_i[1] = 1'b1;
        step(300);
        chk("B_restart", int'(out_o[1]), 0);
        step(150);
        chk("B_rise", int'(out_o[1]), 1);

        // stalled consumer, channels 0 then 3 flip
        evt_if.evt_ready = 1'b0;
        in_i[0] = 1'b1;
        step(100);
        in_i[3] = 1'b1;
        step(450);
        chk("C_out", int'(out_o), 4'b1111);
        chk("C_ovf", int'(ovf_o), (CAP == 1) ? 1 : 0);
        chk("C_head_ch", int'(evt_if.evt_ch), 0);
        evt_if.evt_ready = 1'b1;
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        step(8);
        chk("C_drained", int'(evt_if.evt_valid), 0);
        chk("C_ovf_clr", int'(ovf_o), 0);

        // full buffer: drain in the arrival cycle stores the new event
        evt_if.evt_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 4000; k++) begin
            in_i = ~m_lvl;
            if (exp_q.size() == CAP && flip_next) begin found = 1; break; end
            step(1);
        end
        if (!found) tmo("D_full_accept");
        evt_if.evt_ready = 1'b1;
        step(1);
        evt_if.evt_ready = 1'b0;
        chk("D_store_ovf", int'(ovf_o), 0);
        chk("D_store_valid", int'(evt_if.evt_valid), 1);

        // clear coinciding with a drop: the drop wins
        found = 0;
        for (int k = 0; k < 4000; k++) begin
            in_i = ~m_lvl;
            if (exp_q.size() == CAP && flip_next) begin found = 1; break; end
            step(1);
        end
        if (!found) tmo("D_full_drop");
        ovf_clr_i = 1'b1;
        step(1);
        ovf_clr_i = 1'b0;
        chk("D_clr_vs_drop", int'(ovf_o), 1);

        // reset mid-count with an event pending
        in_i = m_lvl ^ 4'b0001;
        found = 0;
        for (int k = 0; k < 1000; k++) begin
            if (run[0] == 10) begin found = 1; break; end
            step(1);
        end
        if (!found) tmo("E_cnt10");
        rst = 1'b1;
        #1;
        chk("E_out", int'(out_o), 0);
        chk("E_valid", int'(evt_if.evt_valid), 0);
        chk("E_ovf", int'(ovf_o), 0);
        chk("E_evt_ch", int'(evt_if.evt_ch), 0);
        chk("E_evt_level", int'(evt_if.evt_level), 0);
        in_i = 4'b0001;
        evt_if.evt_ready = 1'b1;
        step(2);
        rst = 1'b0;
        // ch0 serves land on cycles 8, 40, ...; the 12th is cycle 360
        step(359);
        chk("E_pre_flip", int'(out_o), 0);
        step(1);
        chk("E_flip", int'(out_o), 4'b0001);

        // randomized traffic: sparse input toggles, bursty ready, random clears
        for (int k = 0; k < 16000; k++) begin
            evt_if.evt_ready = ($urandom_range(0, 7) == 0);
            ovf_clr_i = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 599) == 0) begin
                int idx;
                idx = $urandom_range(0, N_CH - 1);
                in_i[idx] = ~in_i[idx];
            end
            step(1);
        end
        ovf_clr_i = 1'b0;
        evt_if.evt_ready = 1'b1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/debounce_sched.md
DEBOUNCE_SCHED -- requirements
Module: debounce_sched

Interface
REQ-001 Parameter N_CH, default 4: number of raw input channels (power of two, 2..8).
REQ-002 Parameter TICK_DIV, default 8: clk cycles per service slot (>=2).
REQ-003 Parameter DB_MAX, default 12: consecutive mismatching samples needed to flip a channel (2..15).
REQ-004 clk  input  1  single system clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in  input  N_CH  raw bouncing inputs, asynchronous to clk.
REQ-007 out  output  N_CH  debounced levels, registered.
REQ-008 evt_valid  output  1  change event available.
REQ-009 evt_ready  input  1  consumer accepts event when evt_valid high.
REQ-010 evt_ch  output  clog2(N_CH)  channel index of presented event.
REQ-011 evt_level  output  1  new debounced level of presented event.
REQ-012 ovf  output  1  sticky flag: event dropped.
REQ-013 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 Each in bit SHALL pass a 2-flop synchronizer; only synchronized values are sampled.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick asserts one cycle at count TICK_DIV-1.
REQ-016 Pointer ptr SHALL serve channels round-robin 0,1,..,N_CH-1,0; ptr advances by one on every tick; each channel served exactly once per N_CH*TICK_DIV cycles.
REQ-017 One shared compare/increment datapath SHALL service only channel ptr per tick; per-channel counters cnt[ch] (4 bits) held in a register array.
REQ-018 On tick, sync[ptr]==out[ptr]: cnt[ptr] SHALL clear to 0 (any bounce restarts the count).
REQ-019 On tick, mismatch and cnt[ptr]<DB_MAX-1: cnt[ptr] SHALL increment by 1.
REQ-020 On tick, mismatch and cnt[ptr]==DB_MAX-1: out[ptr] SHALL invert on the following clk edge, cnt[ptr] clears, one event {ptr, new level} is generated.
REQ-021 Unserved channels' cnt and out SHALL hold.
REQ-022 Event buffer SHALL be valid/ready: an event transfers when evt_valid&&evt_ready at a clk edge; evt_ch/evt_level stable while evt_valid high and not accepted.
REQ-023 evt_valid, evt_ch, evt_level SHALL update in the same cycle out[ch] changes.
REQ-024 New event with buffer full and no accept that cycle: new event SHALL be dropped, ovf set; out still flips.
REQ-025 New event with buffer full and accept same cycle: SHALL be stored (no drop, no ovf).
REQ-026 ovf_clr and a simultaneous drop: set wins, ovf stays 1.
REQ-027 At most one event is generated per clk (guaranteed by single served channel).

Reset
REQ-028 rst high SHALL asynchronously force: out=0, cnt all 0, synchronizers 0, prescaler 0, ptr 0, evt_valid 0, evt_ch 0, evt_level 0, ovf 0, buffer empty.
REQ-029 rst asserted mid-count or with pending event SHALL discard all progress and events; no event is emitted for the reset-induced level.
REQ-030 After rst deassert, first tick SHALL occur TICK_DIV cycles later, serving channel 0.

Configuration
REQ-031 Macro DEBOUNCE_SCHED_EVT_FIFO_EN defined: event buffer SHALL be a 4-entry FIFO, in-order; full = 4 entries; REQ-024/025 apply to the full condition.
REQ-032 Macro undefined: event buffer SHALL be a single-entry holding register; full = evt_valid high.

Verification (N_CH=4, TICK_DIV=8, DB_MAX=12; service period 32 cycles)
REQ-033 Steady in[2] 0->1, evt_ready=1 -> out[2] rises after exactly 12 channel-2 serves (~384 cycles + sync); one event ch=2 level=1; no other out bit moves.
REQ-034 in[1]=1 with a one-sample 0 glitch at serve 8 -> cnt[1] clears; out[1] rises only after 12 further consecutive mismatching serves.
REQ-035 evt_ready=0, channels 0 and 3 flip in turn -> single-entry build: ch0 event held, ch3 dropped, ovf=1; FIFO build: both events queued, ovf=0, delivered ch0 then ch3.
REQ-036 Buffer full, evt_ready pulsed in the cycle a new event arrives -> new event stored, ovf stays 0; ovf_clr with simultaneous drop -> ovf=1.
REQ-037 rst asserted at cnt[0]=10 with event pending -> all outputs 0 immediately; after release, in[0]=1 needs full 12 serves; first tick 8 cycles after release, ptr=0.
